// File: rtl/ibex_hpm_ctrl_if.sv
// CSR access bus between the CSR decode logic and the performance-counter control block.
// A single-cycle access: no handshake, read data and hit are combinational.
interface ibex_hpm_ctrl_if;
    logic        access;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output access, we, addr, wdata, input rdata, hit);
    modport slave  (input access, we, addr, wdata, output rdata, hit);
endinterface

// File: rtl/ibex_hpm_ctrl.sv
// Control and CSR front-end for the machine performance-counter bank: mcountinhibit,
// mhpmevent selectors, registered events and per-counter increment/write strobes.
module ibex_hpm_ctrl #(
    parameter int unsigned NumHpm    = 8,
    parameter int unsigned NumEvents = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ibex_hpm_ctrl_if.slave             csr,
    input  logic [NumEvents-1:0]       events_i,
    input  logic [(NumHpm+2)*64-1:0]   cnt_val_i,
    output logic [NumHpm+1:0]          cnt_inc_o,
    output logic [NumHpm+1:0]          cnt_we_o,
    output logic [NumHpm+1:0]          cnt_weh_o,
    output logic [31:0]                cnt_wdata_o
);

    localparam int unsigned NumCnt      = NumHpm + 2;
    localparam logic [11:0] AddrInhibit = 12'h320;
    localparam logic [11:0] AddrEvent   = 12'h323;
    localparam logic [11:0] AddrCntLo   = 12'hB00;
    localparam logic [11:0] AddrCntHi   = 12'hB80;

    // One inhibit flop per counter; the unused mcountinhibit bit 1 is not stored.
    logic [NumCnt-1:0]    inhibit_q;
    logic [NumEvents-1:0] event_q [NumHpm];
    logic [NumEvents-1:0] ev_q;

    logic [31:0]       inhibit_rdata;
    logic              inhibit_sel;
    logic [NumHpm-1:0] event_sel;
    logic [NumCnt-1:0] lo_sel;
    logic [NumCnt-1:0] hi_sel;
    logic [NumCnt-1:0] raw_inc;
    logic              wr_en;

    // Counter i lives at offset 0 (mcycle), 2 (minstret), then 3.. for the hpm counters.
    function automatic logic [11:0] cnt_offset(int unsigned i);
        return (i == 0) ? 12'd0 : 12'(i + 1);
    endfunction

    always_comb begin
        inhibit_rdata    = '0;
        inhibit_rdata[0] = inhibit_q[0];
        for (int unsigned j = 1; j < NumCnt; j++) begin
            inhibit_rdata[j+1] = inhibit_q[j];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        csr.hit     = 1'b0;
        csr.rdata   = '0;
        inhibit_sel = 1'b0;
        event_sel   = '0;
        lo_sel      = '0;
        hi_sel      = '0;
        if (csr.addr == AddrInhibit) begin
            csr.hit     = 1'b1;
            csr.rdata   = inhibit_rdata;
            inhibit_sel = 1'b1;
        end
        for (int unsigned k = 0; k < NumHpm; k++) begin
            if (csr.addr == AddrEvent + 12'(k)) begin
                csr.hit      = 1'b1;
                csr.rdata    = 32'(event_q[k]);
                event_sel[k] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NumCnt; i++) begin
            if (csr.addr == AddrCntLo + cnt_offset(i)) begin
                csr.hit   = 1'b1;
                csr.rdata = cnt_val_i[i*64 +: 32];
                lo_sel[i] = 1'b1;
            end
            if (csr.addr == AddrCntHi + cnt_offset(i)) begin
                csr.hit   = 1'b1;
                csr.rdata = cnt_val_i[i*64+32 +: 32];
                hi_sel[i] = 1'b1;
            end
        end
    end

    assign wr_en       = csr.access & csr.we;
    assign cnt_we_o    = lo_sel & {NumCnt{wr_en}};
    assign cnt_weh_o   = hi_sel & {NumCnt{wr_en}};
    assign cnt_wdata_o = csr.wdata;

    // NOTE: the selectors are a handful of flops, not a RAM, so resetting them in a loop is intended.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit_q <= '0;
            ev_q      <= '0;
            for (int unsigned k = 0; k < NumHpm; k++) begin
                event_q[k] <= '0;
            end
        end else begin
            ev_q <= events_i;
            if (wr_en && inhibit_sel) begin
                inhibit_q[0] <= csr.wdata[0];
                for (int unsigned j = 1; j < NumCnt; j++) begin
                    inhibit_q[j] <= csr.wdata[j+1];
                end
            end
            for (int unsigned k = 0; k < NumHpm; k++) begin
                if (wr_en && event_sel[k]) begin
                    event_q[k] <= csr.wdata[NumEvents-1:0];
                end
            end
        end
    end

    always_comb begin
        raw_inc    = '0;
        raw_inc[0] = ev_q[0];
        raw_inc[1] = ev_q[1];
        for (int unsigned k = 0; k < NumHpm; k++) begin
            raw_inc[2+k] = |(ev_q & event_q[k]);
        end
    end

    // A CSR write to a counter drops that cycle's increment rather than deferring it.
    assign cnt_inc_o = raw_inc & ~inhibit_q & ~(cnt_we_o | cnt_weh_o);

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
// Self-checking bench for ibex_hpm_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_ibex_hpm_ctrl;

    localparam int unsigned NumHpm    = 8;
    localparam int unsigned NumEvents = 16;
    localparam int unsigned NumCnt    = NumHpm + 2;
    localparam logic [31:0] InhMask   = 32'(((64'd1 << (NumHpm + 3)) - 64'd1) & ~64'd2);

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NumEvents-1:0]  events_i;
    logic [NumCnt*64-1:0]  cnt_val_i;
    logic [NumCnt-1:0]     cnt_inc_o;
    logic [NumCnt-1:0]     cnt_we_o;
    logic [NumCnt-1:0]     cnt_weh_o;
    logic [31:0]           cnt_wdata_o;

    ibex_hpm_ctrl_if csr_bus ();

    ibex_hpm_ctrl #(.NumHpm(NumHpm), .NumEvents(NumEvents)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .csr         (csr_bus.slave),
        .events_i    (events_i),
        .cnt_val_i   (cnt_val_i),
        .cnt_inc_o   (cnt_inc_o),
        .cnt_we_o    (cnt_we_o),
        .cnt_weh_o   (cnt_weh_o),
        .cnt_wdata_o (cnt_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in for the 64-bit counter instances downstream.
    logic [63:0] cnt [NumCnt] = '{default: 64'd0};

    always @(posedge clk_i) begin
        for (int i = 0; i < NumCnt; i++) begin
            if (cnt_we_o[i])       cnt[i] <= {cnt[i][63:32], cnt_wdata_o};
            else if (cnt_weh_o[i]) cnt[i] <= {cnt_wdata_o, cnt[i][31:0]};
            else if (cnt_inc_o[i]) cnt[i] <= cnt[i] + 64'd1;
        end
    end

    always_comb begin
        cnt_val_i = '0;
        for (int i = 0; i < NumCnt; i++) cnt_val_i[i*64 +: 64] = cnt[i];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural register contents plus last cycle's events.
    logic [31:0]          m_inh;
    logic [31:0]          m_mask [NumHpm];
    logic [NumEvents-1:0] m_evq;

    task automatic model_reset();
        m_inh = '0;
        m_evq = '0;
        for (int k = 0; k < NumHpm; k++) m_mask[k] = '0;
    endtask

    task automatic model_update();
        int a;
        a = int'(csr_bus.addr);
        if (csr_bus.access && csr_bus.we) begin
            if (a == 'h320) m_inh = csr_bus.wdata & InhMask;
            if (a >= 'h323 && a < 'h323 + NumHpm) m_mask[a - 'h323] = csr_bus.wdata & 32'h0000_FFFF;
        end
        m_evq = events_i;
    endtask

    // Counter index for an address, -1 if it is not a counter; hi tells which half.
    function automatic int cnt_index(input int a, output bit hi);
        int off;
        hi  = (a >= 'hB80);
        off = hi ? a - 'hB80 : a - 'hB00;
        if (a < 'hB00 || off < 0) return -1;
        if (off == 0) return 0;
        if (off == 2) return 1;
        if (off >= 3 && off < 3 + NumHpm) return off - 1;
        return -1;
    endfunction

    task automatic model_expect(output logic hit, output logic [31:0] rd,
                                output logic [NumCnt-1:0] we, output logic [NumCnt-1:0] weh,
                                output logic [NumCnt-1:0] inc);
        int a, idx;
        bit hi, wr, raw, inh;
        a  = int'(csr_bus.addr);
        wr = csr_bus.access && csr_bus.we;
        hit = 1'b0; rd = '0; we = '0; weh = '0; inc = '0;
        if (a == 'h320) begin
            hit = 1'b1; rd = m_inh;
        end else if (a >= 'h323 && a < 'h323 + NumHpm) begin
            hit = 1'b1; rd = m_mask[a - 'h323];
        end else begin
            idx = cnt_index(a, hi);
            if (idx >= 0) begin
                hit = 1'b1;
                rd  = hi ? cnt[idx][63:32] : cnt[idx][31:0];
                if (wr && hi)  weh[idx] = 1'b1;
                if (wr && !hi) we[idx]  = 1'b1;
            end
        end
        for (int i = 0; i < NumCnt; i++) begin
            if (i == 0)      raw = m_evq[0];
            else if (i == 1) raw = m_evq[1];
            else             raw = (m_evq & m_mask[i-2][NumEvents-1:0]) != 0;
            inh    = (i == 0) ? m_inh[0] : m_inh[i+1];
            inc[i] = raw && !inh && !we[i] && !weh[i];
        end
    endtask

    task automatic drive(input logic acc, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [NumEvents-1:0] ev);
        csr_bus.access = acc;
        csr_bus.we     = w;
        csr_bus.addr   = a;
        csr_bus.wdata  = d;
        events_i       = ev;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic              acc;
        logic              we;
        logic [11:0]       addr;
        logic [31:0]       wdata;
        logic [15:0]       ev;
        logic              hit;
        logic [31:0]       rdata;
        logic [NumCnt-1:0] we_o;
        logic [NumCnt-1:0] weh_o;
        logic [NumCnt-1:0] inc;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [63:0]       c0_start, c1_start;
        logic              e_hit;
        logic [31:0]       e_rd;
        logic [NumCnt-1:0] e_we, e_weh, e_inc;
        bit                done;

        model_reset();
        drive(1'b0, 1'b0, 12'h000, 32'h0, '0);

        // Reset state: strobes idle while reset is held.
        #3;
        check("reset_inc", 64'(cnt_inc_o), 64'h0);
        check("reset_we", 64'(cnt_we_o | cnt_weh_o), 64'h0);
        #9 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Events 0x3 held four cycles after reset release.
        c0_start = cnt[0];
        c1_start = cnt[1];
        drive(1'b0, 1'b0, 12'h000, 32'h0, 16'h0003);
        #4 check("release_c1_inc", 64'(cnt_inc_o), 64'h0);
        tick();
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) events_i = '0;
            #4 check($sformatf("release_c%0d_inc", c), 64'(cnt_inc_o[1:0]), 64'h3);
            tick();
        end
        #4 check("release_c6_inc", 64'(cnt_inc_o), 64'h0);
        check("mcycle_plus4", cnt[0] - c0_start, 64'd4);
        check("minstret_plus4", cnt[1] - c1_start, 64'd4);
        tick();

        // Directed vectors; mcycle and minstret both hold 4 here.
        tbl[0]  = '{1'b0, 1'b0, 12'h000, 32'h0,        16'h0000, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[1]  = '{1'b1, 1'b1, 12'h320, 32'h5,        16'h0003, 1'b1, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[2]  = '{1'b1, 1'b0, 12'h320, 32'h0,        16'h0000, 1'b1, 32'h5,        10'h000, 10'h000, 10'h000};
        tbl[3]  = '{1'b1, 1'b1, 12'h320, 32'hFFFFFFFF, 16'h0000, 1'b1, 32'h5,        10'h000, 10'h000, 10'h000};
        tbl[4]  = '{1'b1, 1'b0, 12'h320, 32'h0,        16'h0000, 1'b1, 32'h7FD,      10'h000, 10'h000, 10'h000};
        tbl[5]  = '{1'b1, 1'b1, 12'h320, 32'h0,        16'h0000, 1'b1, 32'h7FD,      10'h000, 10'h000, 10'h000};
        tbl[6]  = '{1'b1, 1'b1, 12'h323, 32'h30,       16'h0010, 1'b1, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[7]  = '{1'b1, 1'b0, 12'h323, 32'h0,        16'h0020, 1'b1, 32'h30,       10'h000, 10'h000, 10'h004};
        tbl[8]  = '{1'b0, 1'b0, 12'h000, 32'h0,        16'h0030, 1'b0, 32'h0,        10'h000, 10'h000, 10'h004};
        tbl[9]  = '{1'b0, 1'b0, 12'h000, 32'h0,        16'h0040, 1'b0, 32'h0,        10'h000, 10'h000, 10'h004};
        tbl[10] = '{1'b0, 1'b0, 12'h000, 32'h0,        16'h0000, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[11] = '{1'b0, 1'b0, 12'h000, 32'h0,        16'h0002, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[12] = '{1'b1, 1'b1, 12'hB82, 32'h12345678, 16'h0000, 1'b1, 32'h0,        10'h000, 10'h002, 10'h000};
        tbl[13] = '{1'b1, 1'b0, 12'hB82, 32'h0,        16'h0000, 1'b1, 32'h12345678, 10'h000, 10'h000, 10'h000};
        tbl[14] = '{1'b1, 1'b0, 12'h32B, 32'h0,        16'h0000, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[15] = '{1'b1, 1'b1, 12'h32B, 32'hFFFF,     16'h0000, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[16] = '{1'b1, 1'b1, 12'hB8B, 32'h1,        16'h0000, 1'b0, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[17] = '{1'b1, 1'b1, 12'hB8A, 32'h1,        16'h0000, 1'b1, 32'h0,        10'h000, 10'h200, 10'h000};
        tbl[18] = '{1'b1, 1'b0, 12'h32A, 32'h0,        16'h0000, 1'b1, 32'h0,        10'h000, 10'h000, 10'h000};
        tbl[19] = '{1'b0, 1'b1, 12'hB00, 32'hAA,       16'h0001, 1'b1, 32'h4,        10'h000, 10'h000, 10'h000};
        tbl[20] = '{1'b1, 1'b1, 12'hB00, 32'h0,        16'h0000, 1'b1, 32'h4,        10'h001, 10'h000, 10'h000};

        for (int r = 0; r < 21; r++) begin
            drive(tbl[r].acc, tbl[r].we, tbl[r].addr, tbl[r].wdata, tbl[r].ev);
            #4;
            check($sformatf("vec%0d_hit", r), 64'(csr_bus.hit), 64'(tbl[r].hit));
            check($sformatf("vec%0d_rdata", r), 64'(csr_bus.rdata), 64'(tbl[r].rdata));
            check($sformatf("vec%0d_we", r), 64'(cnt_we_o), 64'(tbl[r].we_o));
            check($sformatf("vec%0d_weh", r), 64'(cnt_weh_o), 64'(tbl[r].weh_o));
            check($sformatf("vec%0d_inc", r), 64'(cnt_inc_o), 64'(tbl[r].inc));
            tick();
        end

        // Reset mid-stream with all events active.
        drive(1'b1, 1'b1, 12'h323, 32'hFFFF, 16'hFFFF);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 16'hFFFF);
        #1 check("midrst_inc_before", 64'(cnt_inc_o), 64'h007);
        rst_ni = 1'b0;
        #1 check("midrst_inc_async", 64'(cnt_inc_o), 64'h0);
        model_reset();
        #4 rst_ni = 1'b1;
        drive(1'b1, 1'b0, 12'h320, 32'h0, '0);
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(posedge clk_i);
            done = 1'b1;
        end
        check("midrst_clock_resumed", 64'(done), 64'h1);
        #1;
        #4 check("midrst_inh_read", 64'(csr_bus.rdata), 64'h0);
        check("midrst_inc_after", 64'(cnt_inc_o), 64'h0);
        tick();
        drive(1'b1, 1'b0, 12'h323, 32'h0, '0);
        #4 check("midrst_evt_read", 64'(csr_bus.rdata), 64'h0);
        tick();

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            case ($urandom_range(0, 5))
                0:       a = 12'h320 + 12'($urandom_range(0, 2));
                1, 2:    a = 12'h323 + 12'($urandom_range(0, NumHpm));
                3:       a = 12'hB00 + 12'($urandom_range(0, NumHpm + 3));
                4:       a = 12'hB80 + 12'($urandom_range(0, NumHpm + 3));
                default: a = 12'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, 1'($urandom), a,
                  ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & 32'h0000_00FF),
                  ($urandom_range(0, 2) == 0) ? '0 : NumEvents'($urandom));
            #4;
            model_expect(e_hit, e_rd, e_we, e_weh, e_inc);
            check($sformatf("rnd%0d_hit", n), 64'(csr_bus.hit), 64'(e_hit));
            check($sformatf("rnd%0d_rdata", n), 64'(csr_bus.rdata), 64'(e_rd));
            check($sformatf("rnd%0d_we", n), 64'(cnt_we_o), 64'(e_we));
            check($sformatf("rnd%0d_weh", n), 64'(cnt_weh_o), 64'(e_weh));
            check($sformatf("rnd%0d_inc", n), 64'(cnt_inc_o), 64'(e_inc));
            check($sformatf("rnd%0d_wdata", n), 64'(cnt_wdata_o), 64'(csr_bus.wdata));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_hpm_ctrl.md
# ibex_hpm_ctrl

Control and CSR front-end for the machine performance-counter bank: owns `mcountinhibit` and the `mhpmevent` selectors, registers raw core events, and drives the increment, write-enable and write-data inputs of each 64-bit `ibex_counter` instance. It also returns counter and control values on the CSR read path. It sits between the CSR decode logic in `ibex_cs_registers` and the counter instances, one stage upstream of them.

## Interface
- `NumHpm`, 8: number of `mhpmcounter` instances (0..29).
- `NumEvents`, 16: width of the raw event vector.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `csr_access_i` in 1: a CSR instruction is accessing `csr_addr_i` this cycle.
- `csr_we_i` in 1: the access writes; only valid with `csr_access_i`.
- `csr_addr_i` in 12: CSR address.
- `csr_wdata_i` in 32: write data.
- `csr_rdata_o` out 32: read data (combinational).
- `csr_hit_o` out 1: the address is owned by this block (combinational).
- `events_i` in NumEvents: raw single-cycle event pulses from the core.
  - bit0 = active cycle.
  - bit1 = instruction retired.
- `cnt_val_i` in (NumHpm+2)*64: counter values from the instances.
  - Index 0 = `mcycle`, index 1 = `minstret`, index 2+k = `mhpmcounter(3+k)`.
- `cnt_inc_o` out NumHpm+2: per-counter increment.
- `cnt_we_o` out NumHpm+2: per-counter low-half write.
- `cnt_weh_o` out NumHpm+2: per-counter high-half write.
- `cnt_wdata_o` out 32: shared write data, equal to `csr_wdata_i`.

## Operation
- Address map:
  - `mcountinhibit` 0x320.
  - `mhpmevent(3+k)` at 0x323+k.
  - `mcycle` 0xB00 / `mcycleh` 0xB80.
  - `minstret` 0xB02 / `minstreth` 0xB82.
  - `mhpmcounter(3+k)` at 0xB03+k / 0xB83+k.
  - All apply for k < NumHpm. Any other address: `csr_hit_o`=0, `csr_rdata_o`=0.
- `mcountinhibit` register:
  - Bit0 inhibits `mcycle`, bit2 inhibits `minstret`, bit 3+k inhibits hpm k.
  - Bit1 and bits above 2+NumHpm are hardwired 0: not writable, read 0.
- `mhpmevent(3+k)`: NumEvents-bit one-hot-or-multi-hot mask. Reads are zero-extended. Written bits above NumEvents are dropped.
- Control-register write: in the cycle where `csr_access_i & csr_we_i` are high and the address is a control register, the register is updated at the clock edge.
- Counter write:
  - A low-half address asserts `cnt_we_o[i]` combinationally in the same cycle.
  - A high-half address asserts `cnt_weh_o[i]` combinationally in the same cycle.
  - No strobe is asserted unless `csr_access_i & csr_we_i`.
- Event pipeline: `ev_q <= events_i` every cycle.
- Raw increment per counter, computed from `ev_q`:
  - `mcycle` = `ev_q[0]`.
  - `minstret` = `ev_q[1]`.
  - hpm k = |(`ev_q` & `mhpmevent_k`).
- Final increment: `cnt_inc_o[i]` = raw & ~inhibit_i & ~(`cnt_we_o[i]` | `cnt_weh_o[i]`). A CSR write always wins over a pending increment, and that increment is dropped, not deferred.
- Read data: `csr_rdata_o` returns the selected 32-bit half of `cnt_val_i`, or the control register. The read uses the pre-write value in a write cycle.
- Reset state: `mcountinhibit`=0, all `mhpmevent`=0, `ev_q`=0.
  - Hence `cnt_inc_o`=0, `cnt_we_o`=0 and `cnt_weh_o`=0 until the first clock after reset release with events present.
  - `cnt_wdata_o` follows `csr_wdata_i`.
  - `csr_rdata_o` / `csr_hit_o` follow their inputs.
- Reset mid-operation: all registers clear asynchronously and `cnt_inc_o` drops immediately. Counter values are owned by the instances and are not touched here.

## Timing
- Event to increment: an event at cycle N produces `cnt_inc_o` in cycle N+1, and the counter value updates at the end of N+1.
- Inhibit/event-mask writes at cycle N take effect on `cnt_inc_o` from cycle N+1. That is, they gate `ev_q` captured from events at cycle N.
- Counter writes: the strobe is in the same cycle as the CSR access, and the new value is visible on `cnt_val_i` at N+1.
- Write to `mcountinhibit` in the same cycle as an event: the event at N is gated by the new inhibit value.
- There are no stalls and no handshake. Every access completes in a single cycle.

## Test plan
- Reset release, `events_i`=0x0003 held for 4 cycles:
  - `cnt_inc_o[1:0]`=2'b11 from cycle 2 onward.
  - `mcycle` and `minstret` each +4 after 5 cycles.
- Write 0x00000005 to 0x320, then pulse `events_i`=0x0003:
  - `cnt_inc_o[1:0]`=0.
  - Reading 0x320 returns 0x00000005.
  - Writing 0xFFFFFFFF and reading back returns 0x000007FD for NumHpm=8.
- Write `mhpmevent3`=0x0030, then apply events 0x0010, 0x0020 and 0x0030 on successive cycles: `cnt_inc_o[2]`=1 on each following cycle. Event 0x0040 gives 0.
- Write 0xB82 with 0x12345678 while `ev_q[1]`=1:
  - `cnt_weh_o[1]`=1 and `cnt_inc_o[1]`=0 in that cycle.
  - Reading 0xB82 next cycle returns 0x12345678.
- Access 0x32B (unimplemented for NumHpm=8) and 0xB8B: `csr_hit_o`=0, rdata 0, and no strobes.
- Assert `rst_ni` low mid-stream with `events_i`=0xFFFF: `cnt_inc_o` goes to 0 asynchronously, and the control registers read 0 after release.
